// File: rtl/fft_twiddle_sequencer.sv
//==============================================================================
// Module  : fft_twiddle_sequencer
// Brief   : Stage/butterfly address sequencer for an in-place radix-2 DIT FFT,
//           driving a registered-address twiddle ROM with aligned operand indices.
//           Optional: FFT_SEQ_STAGE_BARRIER_EN drains S1 before each new stage.
// Revision: 1.0
//==============================================================================
`default_nettype none

module fft_twiddle_sequencer #(
   parameter  int N  = 4096,
   localparam int AW = $clog2(N),
   localparam int SW = $clog2(AW) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] tw_addr,
   output logic          bf_valid,
   input  logic          bf_ready,
   output logic [AW-1:0] addr_a,
   output logic [AW-1:0] addr_b,
   output logic [SW-1:0] bf_stage
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [AW-1:0] ONE_AW     = AW'(1);
   localparam logic [AW-2:0] ONE_B      = (AW-1)'(1);
   localparam logic [SW-1:0] ONE_SW     = SW'(1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(AW - 1);

   state_t        state_q, state_d;
   logic [SW-1:0] s_q, s_d;
   logic [AW-2:0] b_q, b_d;
   logic          valid_q, valid_d;
   logic [AW-1:0] addr_a_q, addr_a_d;
   logic [AW-1:0] addr_b_q, addr_b_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [AW-1:0] tw1_q, tw1_d;
   logic          done_q, done_d;

   logic [AW-1:0] b_ext, span, j_idx, tw_s0, a_s0, b_s0;
   logic [SW-1:0] tw_shift;
   logic          barrier_ok, issue;

   // Butterfly geometry for the counters currently held in S0
   always_comb begin
      b_ext    = {1'b0, b_q};
      span     = ONE_AW << s_q;
      j_idx    = b_ext & (span - ONE_AW);
      tw_shift = LAST_STAGE - s_q;
      tw_s0    = j_idx << tw_shift;
      a_s0     = ((b_ext >> s_q) << (s_q + ONE_SW)) | j_idx;
      b_s0     = a_s0 + span;
   end

`ifdef FFT_SEQ_STAGE_BARRIER_EN
   // The first butterfly of a later stage waits for S1 to be empty at cycle start
   assign barrier_ok = !((s_q != '0) && (b_q == '0)) || !valid_q;
`else
   assign barrier_ok = 1'b1;
`endif

   assign issue = (state_q == ST_RUN) && (!valid_q || bf_ready) && barrier_ok;

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      b_d      = b_q;
      valid_d  = valid_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      stage_d  = stage_q;
      tw1_d    = tw1_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // done_q still counts as busy, so a start in the done cycle is dropped
            if (start && !done_q) begin
               state_d = ST_RUN;
               s_d     = '0;
               b_d     = '0;
            end
         end
         ST_RUN: begin
            if (issue) begin
               valid_d  = 1'b1;
               addr_a_d = a_s0;
               addr_b_d = b_s0;
               stage_d  = s_q;
               tw1_d    = tw_s0;
               if (b_q == '1) begin
                  b_d = '0;
                  if (s_q == LAST_STAGE) begin
                     state_d = ST_FLUSH;
                     s_d     = '0;
                  end else begin
                     s_d = s_q + ONE_SW;
                  end
               end else begin
                  b_d = b_q + ONE_B;
               end
            end else if (valid_q && bf_ready) begin
               valid_d = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (valid_q && bf_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         s_q      <= '0;
         b_q      <= '0;
         valid_q  <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         stage_q  <= '0;
         tw1_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         b_q      <= b_d;
         valid_q  <= valid_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         stage_q  <= stage_d;
         tw1_q    <= tw1_d;
         done_q   <= done_d;
      end
   end

   // During a stall the held twiddle is re-read so ROM data stays aligned with S1
   always_comb begin
      if (valid_q && !bf_ready) begin
         tw_addr = tw1_q;
      end else if (state_q == ST_RUN) begin
         tw_addr = tw_s0;
      end else begin
         tw_addr = '0;
      end
   end

   assign busy     = (state_q != ST_IDLE) || done_q;
   assign done     = done_q;
   assign bf_valid = valid_q;
   assign addr_a   = addr_a_q;
   assign addr_b   = addr_b_q;
   assign bf_stage = stage_q;

endmodule

`default_nettype wire

// File: doc/fft_twiddle_sequencer.md
# fft_twiddle_sequencer

Address sequencer for an in-place radix-2 decimation-in-time FFT over `N` points. It walks all stages and butterflies, drives the read address of the twiddle-factor ROM (single read port, one-cycle registered-address latency, `{32-bit im, 32-bit re}` words), and emits the butterfly operand addresses. The addresses are aligned to the cycle in which the ROM presents the matching twiddle word. It sits between the FFT top-level control and the butterfly/data-RAM datapath.

## Interface
- `N`, 4096, transform size; power of two, ≥ 4.
- `AW`, `$clog2(N)`, address width (derived, not overridden).
- `SW`, `$clog2(AW)+1`, stage index width (derived).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to run one transform; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  single-cycle pulse; the transform is complete.
- `tw_addr`  out  AW  twiddle ROM read address (combinational mux, see Operation).
- `bf_valid`  out  1  `addr_a`/`addr_b`/`bf_stage` valid; ROM `data_out` holds the matching twiddle.
- `bf_ready`  in  1  datapath accepts the current butterfly.
- `addr_a`  out  AW  top operand index.
- `addr_b`  out  AW  bottom operand index (`addr_a + span`).
- `bf_stage`  out  SW  stage of the presented butterfly.

## Operation
- Two-stage pipeline:
  - S0 holds counters `stage` s (0..AW-1) and `b` (0..N/2-1).
  - S1 holds registered `addr_a`, `addr_b`, `bf_stage`, `bf_valid`, and its own twiddle address `tw1`.
- Per butterfly, with `span = 1<<s` and `j = b & (span-1)`:
  - `tw = j << (AW-1-s)`; always < N/2.
  - `addr_a = ((b >> s) << (s+1)) | j`.
  - `addr_b = addr_a + span`.
  - All arithmetic is AW bits; no overflow is possible.
- FSM states:
  - IDLE: leave on `start`.
  - RUN: S0 issues butterflies.
  - FLUSH: S0 is exhausted and S1 is still valid.
  - Return to IDLE with a `done` pulse.
- S0 issues one butterfly when in RUN and `!bf_valid || bf_ready` (S1 free or emptying). On issue, S0 loads S1 and advances `b`. On `b` wrap, `b` returns to 0 and `s` increments. After (s = AW-1, b = N/2-1), go to FLUSH.
- S1 handshake:
  - A transfer occurs when `bf_valid && bf_ready`.
  - While `bf_valid && !bf_ready`, all S1 outputs are held stable.
  - `bf_valid` falls after a transfer unless S0 issued in the same cycle.
- `tw_addr = (bf_valid && !bf_ready) ? tw1 : tw_S0`. This re-reads the held twiddle during a stall so the ROM output stays matched to S1. In IDLE, `tw_S0` = 0.
- `done`: asserted in the cycle after the final butterfly transfer; the FSM is in IDLE in that same cycle. `busy` falls in the cycle after `done`.
- Reset values (on `rst`, mid-transform or not):
  - FSM returns to IDLE; counters cleared.
  - `busy`=0, `done`=0, `bf_valid`=0, `addr_a`=0, `addr_b`=0, `bf_stage`=0, `tw_addr`=0.
  - The in-flight transform is abandoned; no `done` is produced.
- `start` coincident with `rst`: reset wins. `start` during `busy`: ignored, with no queueing.

## Timing
- `start` high in cycle 0:
  - FSM enters RUN in cycle 1, and `tw_addr` for butterfly 0 is driven in cycle 1.
  - `bf_valid` for butterfly 0 is high in cycle 2.
- Sustained throughput with `bf_ready`=1: one butterfly per cycle.
- Minimum total with `bf_ready`=1 and the macro off: `done` in cycle `2 + AW*N/2`.
- `bf_ready` low for k cycles delays every subsequent output by exactly k cycles.

## Configuration
- `FFT_SEQ_STAGE_BARRIER_EN`:
  - Defined: S0 issues the first butterfly of each new stage (s > 0) only in a cycle that begins with S1 empty. This prevents read-after-write hazards in in-place data RAM. With `bf_ready`=1, each stage boundary inserts exactly one cycle of `bf_valid`=0.
  - Undefined: stages issue back-to-back with no bubble.

## Test plan
All scenarios use N=8.
- **Basic run, macro off:** `bf_ready`=1, `start` in cycle 0 -> `bf_valid` high in cycles 2–13, `done` in cycle 14.
  - Stage 0: pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - Stage 1: pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - Stage 2: pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
- **Barrier, macro on, same stimulus:** `bf_valid` high in cycles 2–5, 7–10, 12–15; low in cycles 6 and 11; `done` in cycle 16.
- **Backpressure:** drop `bf_ready` for 3 cycles while stage-2 butterfly (1,5) is presented -> `addr_a`=1, `addr_b`=5, `tw_addr`=1 held throughout the stall; the sequence resumes intact and `done` arrives 3 cycles late.
- **Reset mid-run:** assert `rst` during stage 1 -> the next cycle shows all outputs 0 and the FSM in IDLE; no `done`. A new `start` then reproduces the basic-run sequence exactly.
- **Ignored start:** pulse `start` in cycle 5 of a run -> no effect; exactly one `done`, and the sequence is identical to the basic run.
